instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage of the core: owns the program counter, issues one instruction-memory request at a time and registers each returned word with its PC for decode, where the immediate generator and control decode consume it. Handles decode back-pressure with a one-entry skid buffer, and handles branch/jump redirects, including a redirect that arrives while a memory request is still outstanding.

## Interface
- RESET_PC, 32'h0000_0000: PC of the first fetch after reset; bits [1:0] must be 0.
- NOP, 32'h0000_0013: value driven on oInstruction while nothing valid has been loaded (addi x0,x0,0).

- iClock  in  1  sole clock; all state changes on its rising edge.
- iReset  in  1  synchronous, active-high reset.
- iStall  in  1  decode cannot accept; while oValid && iStall, the oInstruction/oPC/oValid outputs hold.
- iRedirect  in  1  taken branch/jump from execute; priority over everything else.
- iRedirectPC  in  32  redirect target; bits [1:0] are forced to 0 internally.
- oMemReq  out  1  request to instruction memory for address oMemAddr.
- oMemAddr  out  32  fetch address; stable while oMemReq is high and not yet answered.
- iMemReady  in  1  one-cycle response strobe for the current request; memory asserts it only while oMemReq is high.
- iMemData  in  32  instruction word, valid when iMemReady is high.
- oInstruction  out  32  registered instruction for decode.
- oPC  out  32  address of oInstruction.
- oValid  out  1  oInstruction/oPC are a live instruction.

## Operation
- Registers: pc, target (pending redirect), skidInstr, skidPC, state ∈ {FETCH, HOLD, FLUSH}, plus the output registers.
- Output register is free when !oValid || !iStall.
- **Reset:** pc=RESET_PC, state=FETCH, oValid=0, oInstruction=NOP, oPC=RESET_PC. oMemReq=0 while iReset is high.
- **oMemReq / oMemAddr:** oMemReq=1 in FETCH and FLUSH, 0 in HOLD. oMemAddr=pc.
- **FETCH**
  - iRedirect: pc←iRedirectPC&~3 and oValid←0. If iMemReady, discard the response and stay in FETCH. If !iMemReady, target←iRedirectPC&~3, pc is unchanged, and the state goes to FLUSH.
  - iMemReady with the output free: oInstruction←iMemData, oPC←pc, oValid←1, pc←pc+4.
  - iMemReady with the output busy: skidInstr←iMemData, skidPC←pc, pc←pc+4, go to HOLD.
  - No iMemReady with the output free: oValid←0.
- **HOLD** (no request issued)
  - iRedirect: drop the skid, pc←target address, oValid←0, go to FETCH.
  - !iStall: output←skid, oValid←1, go to FETCH.
- **FLUSH:** oMemAddr holds the old pc so the outstanding request is not violated.
  - Every cycle: oValid←0.
  - iRedirect: target←new address (latest wins).
  - iMemReady: discard iMemData, pc←target (or the new iRedirectPC if redirected that same cycle), go to FETCH.
- **Arithmetic:** pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- **Ordering:** no instruction is lost or duplicated absent a redirect. Every instruction is presented in program order exactly once.
- **Reset mid-operation:** reset overrides all states. A response for a request in flight at reset is the memory's responsibility to cancel; fetch ignores iMemReady while iReset is high.

## Timing
- iMemReady→oValid: 1 cycle (registered).
- Throughput with a zero-wait memory (iMemReady in the same cycle as oMemReq): 1 instruction/cycle.
- Redirect penalty:
  - Redirect in FETCH with iMemReady (or in HOLD): first new-path request the next cycle.
  - Redirect with a request outstanding: first new-path request the cycle after the stale iMemReady.
- Stall: at most one response is buffered; requests stop (HOLD) until decode accepts. Leaving HOLD reissues the request the next cycle.
- oValid deasserts the cycle after any iRedirect, independent of iStall.

## Test plan
- **Reset and streaming.**
  - Stimulus: reset 2 cycles, zero-wait memory returning the word 32'h00A00093 + address.
  - Required: first request at addr 0; oPC sequence 0,4,8,C on consecutive cycles with oValid=1; oInstruction=NOP before the first load.
- **Stall and skid.**
  - Stimulus: raise iStall while oPC=4 for 3 cycles.
  - Required: oPC/oInstruction hold at 4; oMemReq drops after the word at 8 is captured.
  - After release: oPC=8, then C; no gaps or duplicates.
- **Redirect with a response in the same cycle.**
  - Stimulus: iRedirect with iRedirectPC=32'h0000_0102 together with iMemReady.
  - Required: next oMemAddr=32'h100; oValid=0 for one cycle; next valid oPC=32'h100.
- **Redirect while a request is outstanding.**
  - Stimulus: 3-cycle-latency memory, redirect to 32'h200 on the 1st wait cycle, second redirect to 32'h300 on the 2nd.
  - Required: oMemAddr stays at the old pc until iMemReady; the stale data never appears on oInstruction; next request is at 32'h300.
- **Wrap-around.**
  - Stimulus: redirect to 32'hFFFF_FFFC.
  - Required: valid oPC=32'hFFFF_FFFC, then next request at 32'h0000_0000.
- **Mid-operation reset.**
  - Stimulus: assert iReset in HOLD with oValid=1.
  - Required: next cycle oValid=0, oMemReq=0, oInstruction=NOP, oPC=RESET_PC; after deassert, fetch resumes at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, keeps one instruction-memory request in flight, and registers
// each returned word with its PC. A one-entry skid absorbs decode stalls; redirects may flush.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0013
) (
   input  logic        iClock,
   input  logic        iReset,
   input  logic        iStall,
   input  logic        iRedirect,
   input  logic [31:0] iRedirectPC,
   output logic        oMemReq,
   output logic [31:0] oMemAddr,
   input  logic        iMemReady,
   input  logic [31:0] iMemData,
   output logic [31:0] oInstruction,
   output logic [31:0] oPC,
   output logic        oValid
);

   typedef enum logic [1:0] {StFetch, StHold, StFlush} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] target;
   logic [31:0] skid_instr;
   logic [31:0] skid_pc;
   logic [31:0] redirect_pc;
   logic        out_free;

   assign redirect_pc = {iRedirectPC[31:2], 2'b00};
   assign out_free    = !oValid || !iStall;
   assign oMemReq     = !iReset && (state != StHold);
   // In FLUSH pc still holds the address of the outstanding request.
   assign oMemAddr    = pc;

   always_ff @(posedge iClock) begin
      if (iReset) begin
         state        <= StFetch;
         pc           <= RESET_PC;
         target       <= RESET_PC;
         skid_instr   <= NOP;
         skid_pc      <= RESET_PC;
         oValid       <= 1'b0;
         oInstruction <= NOP;
         oPC          <= RESET_PC;
      end else begin
         case (state)
            StFetch: begin
               if (iRedirect) begin
                  oValid <= 1'b0;
                  if (iMemReady) begin
                     pc <= redirect_pc;
                  end else begin
                     target <= redirect_pc;
                     state  <= StFlush;
                  end
               end else if (iMemReady) begin
                  if (out_free) begin
                     oInstruction <= iMemData;
                     oPC          <= pc;
                     oValid       <= 1'b1;
                  end else begin
                     skid_instr <= iMemData;
                     skid_pc    <= pc;
                     state      <= StHold;
                  end
                  pc <= pc + 32'd4;
               end else if (out_free) begin
                  oValid <= 1'b0;
               end
            end
            StHold: begin
               if (iRedirect) begin
                  pc     <= redirect_pc;
                  oValid <= 1'b0;
                  state  <= StFetch;
               end else if (!iStall) begin
                  oInstruction <= skid_instr;
                  oPC          <= skid_pc;
                  oValid       <= 1'b1;
                  state        <= StFetch;
               end
            end
            StFlush: begin
               oValid <= 1'b0;
               if (iRedirect) begin
                  target <= redirect_pc;
               end
               // The stale response is dropped; the latest redirect target wins.
               if (iMemReady) begin
                  pc    <= iRedirect ? redirect_pc : target;
                  state <= StFetch;
               end
            end
            default: state <= StFetch;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: streaming, skid/stall, redirects (same-cycle and
// outstanding), PC wrap-around and mid-operation reset, against a latency-configurable memory.
module tb_instruction_fetch;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] BASE = 32'h00A0_0093;

   logic        iClock;
   logic        iReset;
   logic        iStall;
   logic        iRedirect;
   logic [31:0] iRedirectPC;
   logic        oMemReq;
   logic [31:0] oMemAddr;
   logic        iMemReady;
   logic [31:0] iMemData;
   logic [31:0] oInstruction;
   logic [31:0] oPC;
   logic        oValid;

   int unsigned lat;
   int unsigned wait_cnt;
   int          total;
   int          bad;

   instruction_fetch dut (
      .iClock       (iClock),
      .iReset       (iReset),
      .iStall       (iStall),
      .iRedirect    (iRedirect),
      .iRedirectPC  (iRedirectPC),
      .oMemReq      (oMemReq),
      .oMemAddr     (oMemAddr),
      .iMemReady    (iMemReady),
      .iMemData     (iMemData),
      .oInstruction (oInstruction),
      .oPC          (oPC),
      .oValid       (oValid)
   );

   initial iClock = 1'b0;
   always #5 iClock = ~iClock;

   // Memory answers after lat waiting cycles; lat=0 answers in the request cycle.
   always_comb begin
      iMemReady = oMemReq && (wait_cnt >= lat);
      iMemData  = BASE + oMemAddr;
   end

   always_ff @(posedge iClock) begin
      if (iReset || !oMemReq || iMemReady) wait_cnt <= 0;
      else wait_cnt <= wait_cnt + 1;
   end

   task automatic tick();
      @(posedge iClock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      lat         = 0;
      iReset      = 1'b1;
      iStall      = 1'b0;
      iRedirect   = 1'b0;
      iRedirectPC = 32'h0;

      // Reset and streaming
      tick();
      tick();
      chk("rst_valid", {31'd0, oValid}, 32'd0);
      chk("rst_instr", oInstruction, NOP);
      chk("rst_pc", oPC, 32'h0);
      chk("rst_req", {31'd0, oMemReq}, 32'd0);
      iReset = 1'b0;
      #1;
      chk("first_req", {31'd0, oMemReq}, 32'd1);
      chk("first_addr", oMemAddr, 32'h0);
      chk("nop_before_load", oInstruction, NOP);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("stream_valid", {31'd0, oValid}, 32'd1);
         chk("stream_pc", oPC, 32'(4 * i));
         chk("stream_instr", oInstruction, BASE + 32'(4 * i));
      end

      // Stall and skid
      iReset = 1'b1;
      tick();
      tick();
      iReset = 1'b0;
      tick();
      chk("s_pc0", oPC, 32'h0);
      tick();
      chk("s_pc4", oPC, 32'h4);
      iStall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_pc", oPC, 32'h4);
         chk("stall_instr", oInstruction, BASE + 32'h4);
         chk("stall_valid", {31'd0, oValid}, 32'd1);
         chk("stall_req", {31'd0, oMemReq}, 32'd0);
      end
      iStall = 1'b0;
      tick();
      chk("rel_pc8", oPC, 32'h8);
      chk("rel_instr8", oInstruction, BASE + 32'h8);
      chk("rel_valid", {31'd0, oValid}, 32'd1);
      chk("rel_addr", oMemAddr, 32'hC);
      tick();
      chk("rel_pcC", oPC, 32'hC);
      chk("rel_validC", {31'd0, oValid}, 32'd1);

      // Redirect together with a response
      iRedirect   = 1'b1;
      iRedirectPC = 32'h0000_0102;
      tick();
      iRedirect = 1'b0;
      chk("rd_valid0", {31'd0, oValid}, 32'd0);
      chk("rd_addr", oMemAddr, 32'h100);
      tick();
      chk("rd_valid1", {31'd0, oValid}, 32'd1);
      chk("rd_pc", oPC, 32'h100);
      chk("rd_instr", oInstruction, BASE + 32'h100);

      // Redirects while the request to 0x104 is outstanding (3-cycle latency)
      lat         = 3;
      iRedirect   = 1'b1;
      iRedirectPC = 32'h200;
      #1;
      chk("fl_wait_ready", {31'd0, iMemReady}, 32'd0);
      tick();
      chk("fl_addr1", oMemAddr, 32'h104);
      chk("fl_req1", {31'd0, oMemReq}, 32'd1);
      chk("fl_valid1", {31'd0, oValid}, 32'd0);
      iRedirectPC = 32'h300;
      tick();
      iRedirect = 1'b0;
      chk("fl_addr2", oMemAddr, 32'h104);
      chk("fl_valid2", {31'd0, oValid}, 32'd0);
      tick();
      chk("fl_addr3", oMemAddr, 32'h104);
      chk("fl_stale_ready", {31'd0, iMemReady}, 32'd1);
      tick();
      chk("fl_new_addr", oMemAddr, 32'h300);
      chk("fl_valid4", {31'd0, oValid}, 32'd0);
      total++;
      assert (oInstruction !== BASE + 32'h104) else begin
         bad++;
         $error("FAIL fl_stale observed=%h expected=not %h", oInstruction, BASE + 32'h104);
      end
      lat = 0;
      tick();
      chk("fl_pc", oPC, 32'h300);
      chk("fl_instr", oInstruction, BASE + 32'h300);
      chk("fl_valid5", {31'd0, oValid}, 32'd1);

      // Wrap-around
      iRedirect   = 1'b1;
      iRedirectPC = 32'hFFFF_FFFC;
      tick();
      iRedirect = 1'b0;
      chk("wr_valid0", {31'd0, oValid}, 32'd0);
      chk("wr_addr", oMemAddr, 32'hFFFF_FFFC);
      tick();
      chk("wr_pc", oPC, 32'hFFFF_FFFC);
      chk("wr_instr", oInstruction, 32'h00A0_008F);
      chk("wr_next_addr", oMemAddr, 32'h0);
      tick();
      chk("wr_pc0", oPC, 32'h0);
      chk("wr_instr0", oInstruction, BASE);

      // Reset while in HOLD with a valid output
      iStall = 1'b1;
      tick();
      chk("mr_hold_req", {31'd0, oMemReq}, 32'd0);
      chk("mr_hold_valid", {31'd0, oValid}, 32'd1);
      iReset = 1'b1;
      tick();
      chk("mr_valid", {31'd0, oValid}, 32'd0);
      chk("mr_req", {31'd0, oMemReq}, 32'd0);
      chk("mr_instr", oInstruction, NOP);
      chk("mr_pc", oPC, 32'h0);
      iReset = 1'b0;
      iStall = 1'b0;
      #1;
      chk("mr_resume_req", {31'd0, oMemReq}, 32'd1);
      chk("mr_resume_addr", oMemAddr, 32'h0);
      tick();
      chk("mr_resume_pc", oPC, 32'h0);
      chk("mr_resume_valid", {31'd0, oValid}, 32'd1);
      chk("mr_resume_instr", oInstruction, BASE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
